sram_ctrl: RTL and testbench

Sequences 32-bit load/store requests from the LSU onto the 16-bit external asynchronous SRAM (256K x 16).
- Splits each word access into a low and a high half-word phase.
- Generates registered, glitch-free SRAM strobes.
- Returns read data through a req/ready/ack handshake, so the core can stall on memory.
- Sits between lsu and the SRAM_* top-level pins.

---
 rtl/sram_ctrl_pkg.sv | 31 +++
 rtl/sram_ctrl_if.sv | 25 ++
 rtl/sram_phase_timer.sv | 39 +++
 rtl/sram_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_sram_ctrl.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared types and constants for the 32-bit to 16-bit SRAM controller.
//   sram_state_e : controller FSM states
//   sram_half_e  : half-word select (LO = bits [15:0], HI = bits [31:16])
//   SRAM_AW/DW   : external SRAM address/data widths
//   CNT_W        : phase timer width (WAIT_CYCLES up to 15)
package sram_ctrl_pkg;

    localparam int unsigned SRAM_AW = 18;
    localparam int unsigned SRAM_DW = 16;
    localparam int unsigned CNT_W   = 4;

    typedef enum logic [2:0] {
        IDLE,
        LO_SETUP,
        LO_STROBE,
        HI_SETUP,
        HI_STROBE,
        ACK
    } sram_state_e;

    typedef enum logic {
        HALF_LO = 1'b0,
        HALF_HI = 1'b1
    } sram_half_e;

    // Which half-word a given state works on; IDLE/ACK report LO (unused there).
    function automatic sram_half_e state_half(input sram_state_e s);
        return (s == HI_SETUP || s == HI_STROBE) ? HALF_HI : HALF_LO;
    endfunction

endpackage

// File: rtl/sram_ctrl_if.sv
// sram_ctrl_if: LSU-side request/response bundle of the SRAM controller.
//   i_req/i_wren/i_addr/i_wdata/i_bmask : request, driven by the LSU (master)
//   o_ready/o_ack/o_rdata               : status and load data, driven by the controller (slave)
interface sram_ctrl_if;

    logic        i_req;
    logic        i_wren;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic [3:0]  i_bmask;
    logic        o_ready;
    logic        o_ack;
    logic [31:0] o_rdata;

    modport master (
        output i_req, i_wren, i_addr, i_wdata, i_bmask,
        input  o_ready, o_ack, o_rdata
    );

    modport slave (
        input  i_req, i_wren, i_addr, i_wdata, i_bmask,
        output o_ready, o_ack, o_rdata
    );

endinterface

// File: rtl/sram_phase_timer.sv
// sram_phase_timer: loadable down-counter timing one strobe phase.
//   i_clk/i_rst : clock, asynchronous active-high reset
//   i_load      : reload with WAIT_CYCLES (first strobe cycle follows)
//   i_en        : count down (asserted while in a strobe state)
//   o_done      : current cycle is the last strobe cycle
module sram_phase_timer
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_load,
    input  logic i_en,
    output logic o_done
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_load) begin
            cnt_d = CNT_W'(WAIT_CYCLES);
        end else if (i_en && cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_done = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/sram_ctrl.sv
// sram_ctrl: runs 32-bit LSU loads/stores as two 16-bit phases on an async 256K x 16 SRAM.
//   i_clk, i_rst        : clock, asynchronous active-high reset
//   lsu (slave modport) : req/ready/ack handshake, address, store data/byte mask, load data
//   SRAM_ADDR, SRAM_DQ  : half-word address, bidirectional data bus
//   SRAM_CE/WE/OE/LB/UB_N : active-low strobes, all registered
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    sram_ctrl_if.slave         lsu,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    inout  wire  [SRAM_DW-1:0] SRAM_DQ,
    output logic               SRAM_CE_N,
    output logic               SRAM_WE_N,
    output logic               SRAM_OE_N,
    output logic               SRAM_LB_N,
    output logic               SRAM_UB_N
);

    sram_state_e state_q, state_d;

    // Latched request
    logic [16:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  bmask_q;
    logic        wren_q;

    // Registered pins
    logic [SRAM_AW-1:0] sram_addr_q, sram_addr_d;
    logic [SRAM_DW-1:0] dq_out_q, dq_out_d;
    logic               dq_oe_q, dq_oe_d;
    logic               ce_n_q, ce_n_d, we_n_q, we_n_d, oe_n_q, oe_n_d;
    logic               lb_n_q, lb_n_d, ub_n_q, ub_n_d;
    logic               ack_q, ack_d;
    logic [31:0]        rdata_q, rdata_d;

    logic        accept;
    logic        timer_done;
    logic        setup_d, strobe_d;
    logic        half_bit;
    logic [16:0] cur_addr;
    logic [31:0] cur_wdata;
    logic [3:0]  cur_bmask;
    logic        cur_wren;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{lsu.i_addr[31:19], lsu.i_addr[1:0]};

    sram_phase_timer #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_timer (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_load (state_q == LO_SETUP || state_q == HI_SETUP),
        .i_en   (state_q == LO_STROBE || state_q == HI_STROBE),
        .o_done (timer_done)
    );

    // Next state
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (lsu.i_req) begin
                    accept = 1'b1;
                    // Stores skip half-words with no enabled bytes; loads always do both.
                    if (!lsu.i_wren || lsu.i_bmask[1:0] != 2'b00) begin
                        state_d = LO_SETUP;
                    end else if (lsu.i_bmask[3:2] != 2'b00) begin
                        state_d = HI_SETUP;
                    end else begin
                        state_d = ACK;
                    end
                end
            end
            LO_SETUP:  state_d = LO_STROBE;
            LO_STROBE: begin
                if (timer_done) begin
                    state_d = (wren_q && bmask_q[3:2] == 2'b00) ? ACK : HI_SETUP;
                end
            end
            HI_SETUP:  state_d = HI_STROBE;
            HI_STROBE: if (timer_done) state_d = ACK;
            ACK:       state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Pins are decoded from the next state so they change together with it, from flops.
    always_comb begin
        cur_addr  = accept ? lsu.i_addr[18:2] : addr_q;
        cur_wdata = accept ? lsu.i_wdata      : wdata_q;
        cur_bmask = accept ? lsu.i_bmask      : bmask_q;
        cur_wren  = accept ? lsu.i_wren       : wren_q;

        setup_d  = (state_d == LO_SETUP)  || (state_d == HI_SETUP);
        strobe_d = (state_d == LO_STROBE) || (state_d == HI_STROBE);
        half_bit = state_half(state_d);

        sram_addr_d = sram_addr_q;
        dq_out_d    = dq_out_q;
        if (setup_d) begin
            sram_addr_d = {cur_addr, half_bit};
            if (cur_wren) begin
                dq_out_d = half_bit ? cur_wdata[31:16] : cur_wdata[15:0];
            end
        end

        ce_n_d = !(setup_d || strobe_d);
        we_n_d = !(strobe_d && cur_wren);
        oe_n_d = !(strobe_d && !cur_wren);
        lb_n_d = 1'b1;
        ub_n_d = 1'b1;
        if (strobe_d) begin
            if (cur_wren) begin
                lb_n_d = ~cur_bmask[{half_bit, 1'b0}];
                ub_n_d = ~cur_bmask[{half_bit, 1'b1}];
            end else begin
                lb_n_d = 1'b0;
                ub_n_d = 1'b0;
            end
        end

        // Keep driving DQ one extra cycle after WE_N rises for data hold.
        dq_oe_d = ((setup_d || strobe_d) && cur_wren) || !we_n_q;
        ack_d   = (state_d == ACK);

        rdata_d = rdata_q;
        if (!wren_q && timer_done) begin
            if (state_q == LO_STROBE) begin
                rdata_d[15:0] = SRAM_DQ;
            end else if (state_q == HI_STROBE) begin
                rdata_d[31:16] = SRAM_DQ;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            bmask_q     <= '0;
            wren_q      <= 1'b0;
            sram_addr_q <= '0;
            dq_out_q    <= '0;
            dq_oe_q     <= 1'b0;
            ce_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            lb_n_q      <= 1'b1;
            ub_n_q      <= 1'b1;
            ack_q       <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q  <= lsu.i_addr[18:2];
                wdata_q <= lsu.i_wdata;
                bmask_q <= lsu.i_bmask;
                wren_q  <= lsu.i_wren;
            end
            sram_addr_q <= sram_addr_d;
            dq_out_q    <= dq_out_d;
            dq_oe_q     <= dq_oe_d;
            ce_n_q      <= ce_n_d;
            we_n_q      <= we_n_d;
            oe_n_q      <= oe_n_d;
            lb_n_q      <= lb_n_d;
            ub_n_q      <= ub_n_d;
            ack_q       <= ack_d;
            rdata_q     <= rdata_d;
        end
    end

    assign lsu.o_ready = (state_q == IDLE);
    assign lsu.o_ack   = ack_q;
    assign lsu.o_rdata = rdata_q;

    assign SRAM_ADDR = sram_addr_q;
    assign SRAM_DQ   = dq_oe_q ? dq_out_q : {SRAM_DW{1'bz}};
    assign SRAM_CE_N = ce_n_q;
    assign SRAM_WE_N = we_n_q;
    assign SRAM_OE_N = oe_n_q;
    assign SRAM_LB_N = lb_n_q;
    assign SRAM_UB_N = ub_n_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: directed bench for sram_ctrl. One instance (WAIT_CYCLES=1) talks to a small
// behavioural SRAM; a second (WAIT_CYCLES=3) sees a fixed read pattern for back-to-back loads.
module tb_sram_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sram_ctrl_if ifc ();
    sram_ctrl_if ifc3 ();

    logic [17:0] sram_addr, addr3;
    logic        ce_n, we_n, oe_n, lb_n, ub_n;
    logic        ce3_n, we3_n, oe3_n, lb3_n, ub3_n;
    wire  [15:0] sram_dq;
    wire  [15:0] dq3;

    sram_ctrl #(.WAIT_CYCLES(1)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .lsu       (ifc),
        .SRAM_ADDR (sram_addr),
        .SRAM_DQ   (sram_dq),
        .SRAM_CE_N (ce_n),
        .SRAM_WE_N (we_n),
        .SRAM_OE_N (oe_n),
        .SRAM_LB_N (lb_n),
        .SRAM_UB_N (ub_n)
    );

    sram_ctrl #(.WAIT_CYCLES(3)) dut3 (
        .i_clk     (clk),
        .i_rst     (rst),
        .lsu       (ifc3),
        .SRAM_ADDR (addr3),
        .SRAM_DQ   (dq3),
        .SRAM_CE_N (ce3_n),
        .SRAM_WE_N (we3_n),
        .SRAM_OE_N (oe3_n),
        .SRAM_LB_N (lb3_n),
        .SRAM_UB_N (ub3_n)
    );

    // Behavioural SRAM, aliased to 1K half-words (enough for the addresses used).
    logic [15:0] mem [0:1023];
    assign sram_dq = (!ce_n && !oe_n && we_n) ? mem[sram_addr[9:0]] : 16'hzzzz;
    always @(posedge clk) begin
        if (!ce_n && !we_n) begin
            if (!lb_n) mem[sram_addr[9:0]][7:0]  <= sram_dq[7:0];
            if (!ub_n) mem[sram_addr[9:0]][15:8] <= sram_dq[15:8];
        end
    end

    assign dq3 = !oe3_n ? 16'h1234 : 16'hzzzz;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        wren;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  bmask;
        int          lat;
        logic [31:0] rdata;
        int          we_cnt;
        int          oe_cnt;
        int          ce_cnt;
        logic [17:0] a0;
        logic [15:0] d0;
        logic [17:0] a1;
        logic [15:0] d1;
        logic [1:0]  lbub;   // {LB_N, UB_N} at the last WE-low sample
    } vec_t;

    vec_t vecs [10];

    task automatic run_access(input vec_t v, input string tag);
        int          n, we_c, oe_c, ce_c;
        bit          acked, first;
        logic [17:0] fa, la;
        logic [15:0] fd, ld;
        logic [1:0]  lbub;
        n = 0; we_c = 0; oe_c = 0; ce_c = 0; acked = 0; first = 1;
        fa = '0; la = '0; fd = '0; ld = '0; lbub = 2'b11;
        @(negedge clk);
        chk({tag, " ready"}, 32'(ifc.o_ready), 32'd1);
        ifc.i_req   = 1'b1;
        ifc.i_wren  = v.wren;
        ifc.i_addr  = v.addr;
        ifc.i_wdata = v.wdata;
        ifc.i_bmask = v.bmask;
        @(posedge clk);
        #1 ifc.i_req = 1'b0;
        while (!acked && n < 40) begin
            @(negedge clk);
            n++;
            if (ifc.o_ack) begin
                acked = 1;
            end else begin
                if (!ce_n) ce_c++;
                if (!oe_n) oe_c++;
                if (!we_n) begin
                    we_c++;
                    if (first) begin
                        fa = sram_addr; fd = sram_dq; first = 0;
                    end
                    la = sram_addr; ld = sram_dq; lbub = {lb_n, ub_n};
                end
            end
        end
        chk({tag, " latency"}, acked ? 32'(n) : 32'hffff_ffff, 32'(v.lat));
        chk({tag, " ce cycles"}, 32'(ce_c), 32'(v.ce_cnt));
        chk({tag, " oe cycles"}, 32'(oe_c), 32'(v.oe_cnt));
        chk({tag, " we cycles"}, 32'(we_c), 32'(v.we_cnt));
        if (v.we_cnt > 0) begin
            chk({tag, " first we addr"}, 32'(fa), 32'(v.a0));
            chk({tag, " first we dq"}, 32'(fd), 32'(v.d0));
            chk({tag, " last we addr"}, 32'(la), 32'(v.a1));
            chk({tag, " last we dq"}, 32'(ld), 32'(v.d1));
            chk({tag, " lb/ub"}, 32'(lbub), 32'(v.lbub));
            chk({tag, " dq hold in ack"}, 32'(sram_dq), 32'(v.d1));
        end
        if (!v.wren) chk({tag, " rdata"}, ifc.o_rdata, v.rdata);
        @(negedge clk);
        chk({tag, " ack pulse"}, 32'(ifc.o_ack), 32'd0);
        chk({tag, " dq released"}, {16'h0, sram_dq}, {16'h0, 16'hzzzz});
        chk({tag, " ready after"}, 32'(ifc.o_ready), 32'd1);
    endtask

    task automatic chk_idle_pins(input string tag);
        chk({tag, " ready"}, 32'(ifc.o_ready), 32'd1);
        chk({tag, " ack"}, 32'(ifc.o_ack), 32'd0);
        chk({tag, " rdata"}, ifc.o_rdata, 32'd0);
        chk({tag, " addr"}, 32'(sram_addr), 32'd0);
        chk({tag, " strobes"}, {27'd0, ce_n, we_n, oe_n, lb_n, ub_n}, 32'h1f);
        chk({tag, " dq"}, {16'h0, sram_dq}, {16'h0, 16'hzzzz});
    endtask

    initial begin
        int n, acks, a1, a2, oe3_c, ce3_c, we3_c, bb3_c, ack_seen, ce_seen;
        vec_t post;

        ifc.i_req = 0; ifc.i_wren = 0; ifc.i_addr = '0; ifc.i_wdata = '0; ifc.i_bmask = '0;
        ifc3.i_req = 0; ifc3.i_wren = 0; ifc3.i_addr = '0; ifc3.i_wdata = '0; ifc3.i_bmask = '0;

        //          wren addr           wdata          bm    lat rdata          we oe ce a0       d0        a1       d1        lbub
        vecs[0] = '{1'b1, 32'h0000_0104, 32'hDEAD_BEEF, 4'hF, 5, 32'h0,          2, 0, 4, 18'h82, 16'hBEEF, 18'h83, 16'hDEAD, 2'b00};
        vecs[1] = '{1'b0, 32'h0000_0104, 32'h0,         4'h0, 5, 32'hDEAD_BEEF,  0, 2, 4, 18'h0,  16'h0,    18'h0,  16'h0,    2'b00};
        vecs[2] = '{1'b1, 32'h0000_0008, 32'h1122_3344, 4'hF, 5, 32'h0,          2, 0, 4, 18'h4,  16'h3344, 18'h5,  16'h1122, 2'b00};
        vecs[3] = '{1'b1, 32'h0000_0008, 32'hAA00_0000, 4'h8, 3, 32'h0,          1, 0, 2, 18'h5,  16'hAA00, 18'h5,  16'hAA00, 2'b10};
        vecs[4] = '{1'b0, 32'h0000_0008, 32'h0,         4'h0, 5, 32'hAA22_3344,  0, 2, 4, 18'h0,  16'h0,    18'h0,  16'h0,    2'b00};
        vecs[5] = '{1'b1, 32'h0000_0104, 32'h1234_5678, 4'h0, 1, 32'h0,          0, 0, 0, 18'h0,  16'h0,    18'h0,  16'h0,    2'b00};
        vecs[6] = '{1'b1, 32'h0000_0008, 32'h5555_CAFE, 4'h3, 3, 32'h0,          1, 0, 2, 18'h4,  16'hCAFE, 18'h4,  16'hCAFE, 2'b00};
        vecs[7] = '{1'b0, 32'h0000_0008, 32'h0,         4'h0, 5, 32'hAA22_CAFE,  0, 2, 4, 18'h0,  16'h0,    18'h0,  16'h0,    2'b00};
        vecs[8] = '{1'b1, 32'h0000_0104, 32'h0077_0000, 4'h4, 3, 32'h0,          1, 0, 2, 18'h83, 16'h0077, 18'h83, 16'h0077, 2'b01};
        vecs[9] = '{1'b0, 32'h0008_0106, 32'h0,         4'h0, 5, 32'hDE77_BEEF,  0, 2, 4, 18'h0,  16'h0,    18'h0,  16'h0,    2'b00};

        // Reset state
        repeat (2) @(negedge clk);
        chk_idle_pins("reset");
        rst = 1'b0;

        // Back-to-back loads on the WAIT_CYCLES=3 instance with i_req held high.
        @(negedge clk);
        chk("b2b ready", 32'(ifc3.o_ready), 32'd1);
        ifc3.i_req  = 1'b1;
        ifc3.i_wren = 1'b0;
        ifc3.i_addr = 32'h0000_0040;
        @(posedge clk);
        n = 0; acks = 0; a1 = -1; a2 = -1; oe3_c = 0; ce3_c = 0; we3_c = 0; bb3_c = 0;
        while (acks < 2 && n < 60) begin
            @(negedge clk);
            n++;
            if (!oe3_n) oe3_c++;
            if (!ce3_n) ce3_c++;
            if (!we3_n) we3_c++;
            if (!lb3_n && !ub3_n) bb3_c++;
            if (n == 5) chk("b2b busy", 32'(ifc3.o_ready), 32'd0);
            if (n == 10) chk("b2b ready after ack", 32'(ifc3.o_ready), 32'd1);
            if (ifc3.o_ack) begin
                acks++;
                chk("b2b rdata", ifc3.o_rdata, 32'h1234_1234);
                chk("b2b addr", 32'(addr3), 32'h21);
                if (acks == 1) begin
                    a1 = n;
                end else begin
                    a2 = n;
                    ifc3.i_req = 1'b0;
                end
            end
        end
        ifc3.i_req = 1'b0;
        chk("b2b first ack", 32'(a1), 32'd9);
        chk("b2b second ack", 32'(a2), 32'd19);
        chk("b2b oe cycles", 32'(oe3_c), 32'd12);
        chk("b2b ce cycles", 32'(ce3_c), 32'd16);
        chk("b2b we cycles", 32'(we3_c), 32'd0);
        chk("b2b byte enables", 32'(bb3_c), 32'd12);

        // Directed vectors on the WAIT_CYCLES=1 instance.
        for (int i = 0; i < 10; i++) begin
            run_access(vecs[i], $sformatf("v%0d", i));
        end

        // Reset in the middle of the HI strobe of a store.
        @(negedge clk);
        ifc.i_req   = 1'b1;
        ifc.i_wren  = 1'b1;
        ifc.i_addr  = 32'h0000_0200;
        ifc.i_wdata = 32'h5555_6666;
        ifc.i_bmask = 4'hF;
        @(posedge clk);
        #1 ifc.i_req = 1'b0;
        repeat (4) @(negedge clk);
        chk("midrst we low", 32'(we_n), 32'd0);
        chk("midrst hi addr", 32'(sram_addr), 32'h101);
        rst = 1'b1;
        #1;
        chk_idle_pins("midrst");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        ack_seen = 0; ce_seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (ifc.o_ack) ack_seen++;
            if (!ce_n) ce_seen++;
        end
        chk("midrst no ack", 32'(ack_seen), 32'd0);
        chk("midrst no ce", 32'(ce_seen), 32'd0);

        // Controller still usable after the abort.
        post = vecs[9];
        post.addr = 32'h0000_0104;
        run_access(post, "postrst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
